// File: rtl/product_accumulator.sv
`timescale 1ns/1ps
// product_accumulator: sums N_TERMS 64-bit products, scales by FRAC_SHIFT.
// Define PRODUCT_ACCUMULATOR_SAT_EN to clamp the scaled sum to 32 bits.
module product_accumulator #(
  parameter int N_TERMS    = 8,
  parameter int FRAC_SHIFT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_sat
);

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    SCALE = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam logic [8:0] LAST = 9'(N_TERMS - 1);

  state_e      state_q, state_d;
  logic [71:0] acc_q, acc_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [31:0] sum_q, sum_d;
  logic        sat_q, sat_d;

  logic [31:0] res_sum;
  logic        res_sat;

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  logic [71:0] scaled;

  assign scaled = acc_q >> FRAC_SHIFT;

  always_comb begin
    res_sat = |scaled[71:32];
    res_sum = res_sat ? 32'hFFFF_FFFF : scaled[31:0];
  end
`else
  assign res_sum = 32'(acc_q >> FRAC_SHIFT);
  assign res_sat = 1'b0;
`endif

  // clr wins over any transfer or handshake in the same cycle
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (in_valid) begin
            acc_d = acc_q + {8'd0, in_prod};
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == LAST) begin
              state_d = SCALE;
            end
          end
        end
        SCALE: begin
          sum_d   = res_sum;
          sat_d   = res_sat;
          state_d = OUT;
        end
        OUT: begin
          if (out_ready) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACC;
          end
        end
        default: begin
          state_d = ACC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign out_sum   = sum_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
`timescale 1ns/1ps
// tb_product_accumulator: randomized scoreboard bench for product_accumulator.
// Second instance covers the single-term, unscaled configuration.
module tb_product_accumulator;

  localparam int NT = 4;
  localparam int FS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clr, in_valid, in_ready;
  logic        out_valid, out_ready, out_sat;
  logic [63:0] in_prod;
  logic [31:0] out_sum;

  logic        clr2, in_valid2, in_ready2;
  logic        out_valid2, out_ready2, out_sat2;
  logic [63:0] in_prod2;
  logic [31:0] out_sum2;

  product_accumulator #(.N_TERMS(NT), .FRAC_SHIFT(FS)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_sat(out_sat)
  );

  product_accumulator #(.N_TERMS(1), .FRAC_SHIFT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_prod(in_prod2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_sum(out_sum2), .out_sat(out_sat2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] exp_q[$];
  logic [71:0] grp_sum;
  int          grp_n;
  time         last_t;
  int          rmode;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Result = (sum of products) >> shift, clamped or truncated to 32 bits
  function automatic logic [32:0] ref_res(input logic [71:0] s,
                                          input int sh);
    logic [71:0] v;
    v = s >> sh;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    if (v > 72'hFFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
`endif
    return {1'b0, v[31:0]};
  endfunction

  task automatic send(input logic [63:0] p);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = p;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      fail_now("send_timeout");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      last_t  = $time;
      grp_sum = grp_sum + {8'd0, p};
      grp_n++;
      if (grp_n == NT) begin
        exp_q.push_back(ref_res(grp_sum, FS));
        grp_sum = '0;
        grp_n   = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0 || out_valid) fail_now("drain_timeout");
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) fail_now("wait_valid_timeout");
  endtask

  // Monitor: drives out_ready, pops and compares on every handshake
  initial begin : mon
    bit          prev, hold, after;
    logic [31:0] hs;
    logic        hsat;
    int          wc;
    logic [32:0] e;
    prev = 0; hold = 0; after = 0; wc = 0;
    hs = '0; hsat = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 0; hold = 0; after = 0; wc = 0;
        continue;
      end
      if (after) begin
        check("ready_after_hs", {62'd0, in_ready, out_valid}, 64'h2);
        after = 0;
      end
      if (out_valid) begin
        if (!prev) check("latency", last_t + 15, $time);
        if (hold) begin
          check("stable_sum", out_sum, hs);
          check("stable_sat", out_sat, hsat);
        end
        check("in_ready_busy", in_ready, 0);
        case (rmode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          2:       out_ready = (wc >= 3);
          default: out_ready = 1'b0;
        endcase
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_result");
          end else begin
            e = exp_q.pop_front();
            check("out_sum", out_sum, e[31:0]);
            check("out_sat", out_sat, e[32]);
          end
          after = 1; hold = 0; wc = 0;
        end else begin
          hold = 1; hs = out_sum; hsat = out_sat;
          wc++;
        end
        prev = 1;
      end else begin
        prev = 0; hold = 0; wc = 0;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : watchdog
    #500000;
    fail_now("watchdog_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : main
    logic [63:0] p;
    logic [32:0] e;
    int          k;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_prod = '0;
    clr2 = 1'b0; in_valid2 = 1'b0; in_prod2 = '0; out_ready2 = 1'b1;
    grp_sum = '0; grp_n = 0; last_t = 0; rmode = 0;

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_sat", out_sat, 0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (4) send(64'h0000_0000_0001_0000);
    drain();

    repeat (4) send(64'h0000_8000_0000_0000);
    drain();

    // Held result while upstream keeps offering data
    rmode = 2;
    repeat (8) send(64'h0000_0000_0003_0000);
    drain();
    rmode = 0;

    // Reset mid-accumulation
    repeat (2) send(64'h0000_0000_0005_0000);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    grp_sum = '0; grp_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) send(64'h0000_0000_0002_0000);
    drain();

    // Reset while a result is pending
    rmode = 3;
    repeat (4) send(64'h0000_0000_00FF_0000);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid();
    rst_n = 1'b0;
    #1;
    check("out_rst_out_valid", out_valid, 0);
    check("out_rst_out_sum", out_sum, 0);
    check("out_rst_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rmode = 0;
    repeat (4) send(64'h0000_0000_0001_0000);
    drain();

    // clr coincident with the third transfer discards it
    repeat (2) send(64'h0000_0000_0001_0000);
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = 64'h0000_0000_0007_0000;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    grp_sum = '0; grp_n = 0;
    repeat (4) send(64'h0000_0000_0001_0000);
    drain();

    // Randomized traffic with random backpressure
    rmode = 1;
    for (int i = 0; i < 48; i++) begin
      case ($urandom_range(0, 2))
        0:       p = {$urandom, $urandom};
        1:       p = {32'd0, $urandom};
        default: p = 64'($urandom) << $urandom_range(0, 24);
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(p);
    end
    drain();
    rmode = 0;

    // Single-term, unscaled instance
    for (int i = 0; i < 4; i++) begin
      p = (i == 0) ? 64'h0000_0000_1234_5678 :
          (i == 1) ? {$urandom, $urandom} : {32'd0, $urandom};
      @(negedge clk);
      in_valid2 = 1'b1;
      in_prod2  = p;
      check("n1_in_ready", in_ready2, 1);
      @(negedge clk);
      in_valid2 = 1'b0;
      k = 0;
      while (!out_valid2 && k < 10) begin
        @(negedge clk);
        k++;
      end
      if (!out_valid2) begin
        fail_now("n1_timeout");
      end else begin
        e = ref_res({8'd0, p}, 0);
        check("n1_out_sum", out_sum2, e[31:0]);
        check("n1_out_sat", out_sat2, e[32]);
      end
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
